// File: rtl/pattern_checker_pkg.sv
// Shared definitions for the LFSR pattern generator and checker.
// The step function lives here so both sides use the same polynomial.
package pattern_checker_pkg;

  localparam int LFSR_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FAIL_MISMATCH = 2'd0;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd1;
  localparam logic [1:0] FAIL_SETUP    = 2'd2;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] q
  );
    return {q[0] ^ q[1], q[3], q[2], q[1]};
  endfunction

endpackage

// File: rtl/pattern_checker_timer.sv
// Per-press idle timer: clear has priority over count enable.
// Expiry is flagged while the count sits at TIMEOUT_CYCLES-1.
module press_timer #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pattern_checker.sv
// Regenerates the LFSR sequence from the round seed and checks each
// player press against it, reporting pass or a coded failure.
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [4:0]        round_len,
  input  logic              press_valid,
  input  logic [LFSR_W-1:0] press_code,
  output logic              press_ready,
  output logic              busy,
  output logic [LFSR_W-1:0] expected,
  output logic [4:0]        index,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code
);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        len_q, len_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [1:0]        code_q, code_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              t_clr;
  logic              t_en;
  logic              t_exp;
  logic              bad_setup;

  press_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (t_clr),
    .en_i     (t_en),
    .expired_o(t_exp)
  );

  // Zero seed would lock the LFSR at zero forever.
  assign bad_setup = (seed == '0) || (round_len == '0) ||
                     (round_len > 5'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    code_d  = code_q;
    t_clr   = 1'b1;
    t_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
          len_d = round_len;
          if (bad_setup) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            code_d  = FAIL_SETUP;
          end else begin
            state_d = S_WAIT;
            exp_d   = lfsr_step(seed);
          end
        end
      end
      S_WAIT: begin
        t_clr = 1'b0;
        t_en  = 1'b1;
        if (press_valid) begin
          if (press_code == exp_q) begin
            if (idx_q == len_q - 5'd1) begin
              state_d = S_DONE;
              pass_d  = 1'b1;
              idx_d   = len_q;
            end else begin
              exp_d = lfsr_step(exp_q);
              idx_d = idx_q + 5'd1;
              t_clr = 1'b1;
            end
          end else begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            code_d  = FAIL_MISMATCH;
          end
        end else if (t_exp) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          code_d  = FAIL_TIMEOUT;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != S_WAIT) begin
      exp_d = '0;
    end
    ready_d = (state_d == S_WAIT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= FAIL_MISMATCH;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign press_ready = ready_q;
  assign busy        = busy_q;
  assign expected    = exp_q;
  assign index       = idx_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = code_q;

endmodule

// File: tb/tb_pattern_checker.sv
// Directed bench for pattern_checker with a pass/fail scoreboard.
module tb_pattern_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] seed;
  logic [4:0] round_len;
  logic       press_valid;
  logic [3:0] press_code;
  logic       press_ready;
  logic       busy;
  logic [3:0] expected;
  logic [4:0] index;
  logic       pass;
  logic       fail;
  logic [1:0] fail_code;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       is_pass;
    logic [1:0] code;
    logic       chk_idx;
    logic [4:0] idx;
  } resp_t;

  resp_t sb[$];

  pattern_checker #(
    .MAX_LEN       (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .seed       (seed),
    .round_len  (round_len),
    .press_valid(press_valid),
    .press_code (press_code),
    .press_ready(press_ready),
    .busy       (busy),
    .expected   (expected),
    .index      (index),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic [1:0] c,
                      input logic ci, input logic [4:0] i);
    resp_t r;
    r.is_pass = p;
    r.code    = c;
    r.chk_idx = ci;
    r.idx     = i;
    sb.push_back(r);
  endtask

  task automatic begin_round(input logic [3:0] s, input logic [4:0] l);
    seed      = s;
    round_len = l;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] c);
    press_valid = 1'b1;
    press_code  = c;
    tick();
    press_valid = 1'b0;
  endtask

  // Monitor: every pass/fail pulse must match the next queued response.
  always @(negedge clk) begin
    if (reset_n && (pass || fail)) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_pulse: pass=%0d fail=%0d", pass, fail);
      end else begin
        resp_t r;
        r = sb.pop_front();
        chk("mon_pass", 32'(pass), 32'(r.is_pass));
        chk("mon_fail", 32'(fail), 32'(!r.is_pass));
        if (!r.is_pass) chk("mon_code", 32'(fail_code), 32'(r.code));
        if (r.chk_idx) chk("mon_index", 32'(index), 32'(r.idx));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] seq4 [4];
  logic [3:0] seq5 [5];

  initial begin
    seq4 = '{4'hC, 4'h6, 4'hB, 4'h5};
    seq5 = '{4'hC, 4'h6, 4'hB, 4'h5, 4'hA};
    reset_n     = 1'b0;
    start       = 1'b0;
    seed        = '0;
    round_len   = '0;
    press_valid = 1'b0;
    press_code  = '0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(press_ready), 0);
    chk("rst_expected", 32'(expected), 0);
    chk("rst_index", 32'(index), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_code", 32'(fail_code), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Clean round with gaps between presses
    begin_round(4'b1001, 5'd4);
    chk("clean_ready", 32'(press_ready), 1);
    chk("clean_busy", 32'(busy), 1);
    chk("clean_index0", 32'(index), 0);
    push(1'b1, 2'd0, 1'b1, 5'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      chk($sformatf("clean_exp%0d", i), 32'(expected), 32'(seq4[i]));
      press(seq4[i]);
    end
    chk("clean_pass_lat", 32'(pass), 1);
    chk("clean_index4", 32'(index), 4);
    tick();
    chk("clean_pass_drop", 32'(pass), 0);
    chk("clean_idle", 32'(busy), 0);
    chk("clean_exp_clr", 32'(expected), 0);
    chk("clean_index_hold", 32'(index), 4);

    // Mismatch on third press
    begin_round(4'b1001, 5'd4);
    push(1'b0, 2'd0, 1'b1, 5'd2);
    press(4'hC);
    press(4'h6);
    press(4'hA);
    chk("mm_fail_lat", 32'(fail), 1);
    chk("mm_code", 32'(fail_code), 0);
    chk("mm_index", 32'(index), 2);
    chk("mm_busy", 32'(busy), 1);
    tick();
    chk("mm_busy_drop", 32'(busy), 0);
    chk("mm_code_hold", 32'(fail_code), 0);

    // Timeout with no press
    begin_round(4'b1001, 5'd2);
    push(1'b0, 2'd1, 1'b1, 5'd0);
    repeat (7) tick();
    chk("to_not_yet", 32'(fail), 0);
    chk("to_ready", 32'(press_ready), 1);
    tick();
    chk("to_fail_lat", 32'(fail), 1);
    chk("to_code", 32'(fail_code), 1);
    tick();

    // Press on the last timer cycle wins over timeout
    begin_round(4'b1001, 5'd2);
    push(1'b1, 2'd0, 1'b1, 5'd2);
    repeat (7) tick();
    press(4'hC);
    chk("edge_no_fail", 32'(fail), 0);
    chk("edge_ready", 32'(press_ready), 1);
    chk("edge_index", 32'(index), 1);
    chk("edge_exp", 32'(expected), 32'(4'h6));
    press(4'h6);
    chk("edge_pass", 32'(pass), 1);
    tick();

    // Bad setup cases
    begin_round(4'h0, 5'd4);
    push(1'b0, 2'd2, 1'b0, 5'd0);
    chk("bs_seed_fail", 32'(fail), 1);
    chk("bs_seed_code", 32'(fail_code), 2);
    chk("bs_seed_ready", 32'(press_ready), 0);
    tick();
    chk("bs_seed_idle", 32'(busy), 0);
    begin_round(4'h9, 5'd0);
    push(1'b0, 2'd2, 1'b0, 5'd0);
    chk("bs_len0_code", 32'(fail_code), 2);
    chk("bs_len0_ready", 32'(press_ready), 0);
    tick();
    begin_round(4'h9, 5'd17);
    push(1'b0, 2'd2, 1'b0, 5'd0);
    chk("bs_len17_fail", 32'(fail), 1);
    chk("bs_len17_ready", 32'(press_ready), 0);
    tick();

    // Press in IDLE is ignored
    press_valid = 1'b1;
    press_code  = 4'hC;
    tick();
    tick();
    press_valid = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_exp", 32'(expected), 0);
    chk("idle_ready", 32'(press_ready), 0);

    // Back-to-back presses with a mid-round start
    begin_round(4'b1001, 5'd5);
    push(1'b1, 2'd0, 1'b1, 5'd5);
    press_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      press_code = seq5[i];
      if (i == 1) begin
        start = 1'b1;
        seed  = 4'h0;
      end else begin
        start = 1'b0;
      end
      tick();
      if (i == 1) chk("b2b_index2", 32'(index), 2);
    end
    press_valid = 1'b0;
    start       = 1'b0;
    chk("b2b_pass", 32'(pass), 1);
    chk("b2b_index5", 32'(index), 5);
    tick();

    // Asynchronous reset mid-round
    begin_round(4'b1001, 5'd4);
    press(4'hC);
    press(4'h6);
    chk("ar_index", 32'(index), 2);
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_ready", 32'(press_ready), 0);
    chk("ar_exp", 32'(expected), 0);
    chk("ar_index0", 32'(index), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    begin_round(4'b1001, 5'd1);
    chk("ar_restart_exp", 32'(expected), 32'(4'hC));
    push(1'b1, 2'd0, 1'b1, 5'd1);
    press(4'hC);
    chk("ar_pass", 32'(pass), 1);
    repeat (3) tick();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_checker.md
Name: pattern_checker

Overview:
- Player-side consumer of the game's 4-bit LFSR pattern generator.
- Given the same seed, it regenerates the LED sequence internally and checks each debounced player press against the expected step.
- Reports pass or fail for the round: mismatch, timeout or bad setup.
- Sits between the button front-end and the game controller FSM.

Parameters:
MAX_LEN, 16, maximum round length in presses; must be 1..31.
TIMEOUT_CYCLES, 50000000, per-press idle limit in clk cycles; must be >= 2.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin checking a round; sampled only in IDLE
seed  input  4  LFSR seed used by the generator for this round
round_len  input  5  number of presses expected this round
press_valid  input  1  player press strobe
press_code  input  4  button code of the press
press_ready  output  1  high while a press can be accepted (state WAIT)
busy  output  1  high in any state other than IDLE
expected  output  4  current expected code (debug/LED replay); 0 outside WAIT
index  output  5  number of presses already matched this round
pass  output  1  one-cycle pulse: full round matched
fail  output  1  one-cycle pulse: round failed
fail_code  output  2  valid with fail: 0 mismatch, 1 timeout, 2 bad setup; holds until next fail

Behaviour:
- Step function, identical to the generator: next = {q[0]^q[1], q[3], q[2], q[1]}.
- Expected sequence: e0 = step(seed), e(k+1) = step(e(k)). The seed itself is never a pressed value.
- Reset (async, reset_n low): state=IDLE, expected=0, index=0, timer=0, pass=0, fail=0, fail_code=0, press_ready=0, busy=0.
- States: IDLE, WAIT, DONE, FAIL. All outputs are registered.
- IDLE:
  - On start=1, check setup. If seed==0 (LFSR lock-up), round_len==0 or round_len>MAX_LEN: go to FAIL with fail_code=2.
  - Otherwise go to WAIT with expected=e0, index=0, timer=0.
  - press_valid is ignored in IDLE.
- WAIT:
  - press_ready=1 and timer increments every cycle.
  - A press is accepted when press_valid=1 (ready is high). Compare is against the registered expected.
  - Match and index==round_len-1: go to DONE, index=round_len.
  - Match otherwise: expected<=step(expected), index+1, timer=0, stay in WAIT. Back-to-back presses on consecutive cycles are legal.
  - Mismatch: go to FAIL with fail_code=0. index holds the count matched so far.
  - Timer reaching TIMEOUT_CYCLES-1 with no press that cycle: go to FAIL with fail_code=1.
  - Press and timeout in the same cycle: the press wins and is evaluated normally.
- DONE: pass=1 for exactly this cycle, then IDLE. expected is cleared to 0; index holds its value until the next start.
- FAIL: fail=1 for exactly this cycle, then IDLE. expected is cleared to 0.
- start while busy is ignored; there is no restart mid-round.
- Latency:
  - start to press_ready: 1 cycle.
  - Final accepted press to pass: 1 cycle.
  - Bad press to fail: 1 cycle.
- reset_n asserted mid-round aborts immediately to reset values; no pulse is emitted.
- Width rules:
  - Timer is ceil(log2(TIMEOUT_CYCLES)) bits and saturates by construction.
  - index is 5 bits; no wrap is possible because round_len<=MAX_LEN<=31.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, WAIT, DONE, FAIL);
  - fail_code constants (FAIL_MISMATCH=0, FAIL_TIMEOUT=1, FAIL_SETUP=2);
  - the LFSR width (4);
  - the step function, which the generator and checker share so the polynomial cannot diverge.
- One sub-module, press_timer: load/clear, enable and expiry flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Clean round:
  - Stimulus: seed=4'b1001, round_len=4, then presses C,6,B,5 with gaps.
  - Required: expected shows C,6,B,5 in turn; pass pulses once 1 cycle after the 4th press; index=4; fail never asserts.
- Mismatch:
  - Stimulus: seed=1001, round_len=4, presses C,6,A.
  - Required: fail pulse with fail_code=0 one cycle after A; index=2; busy drops the cycle after.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, seed=1001, round_len=2, no press.
  - Required: fail with fail_code=1, 8 cycles after entering WAIT.
  - Stimulus: a press at timer=TIMEOUT_CYCLES-1.
  - Required: the press is accepted and there is no timeout.
- Bad setup:
  - Stimulus: seed=0; round_len=0; round_len=MAX_LEN+1.
  - Required: each gives fail_code=2 one cycle after start; press_ready never asserts.
- Back-to-back and ignored inputs:
  - Stimulus: presses on consecutive cycles; start asserted mid-round; press_valid in IDLE.
  - Required: consecutive presses are all checked correctly; the mid-round start has no effect; the IDLE press causes no state change.
- Reset mid-round:
  - Stimulus: reset_n low for 1 cycle after 2 matched presses.
  - Required: all outputs return to reset values asynchronously; there is no pass/fail pulse; a following round with seed=1001 restarts from expected=C.
